uuv_throttle_ctrl: RTL
======================

Name: uuv_throttle_ctrl

Overview:
- Sequences the UUV thruster PWM generator: drives its `ena` and `pos` inputs instead of tying them to constants.
- Implements the ESC arming sequence: neutral is held with the output enabled for a fixed time before commands are accepted.
- Accepts position commands over a valid/ready handshake and slews the output toward the target at a bounded rate.
- Provides an immediate kill path that forces the output safe.

Parameters:
- POS_W, 8, width of position command and output; matches pwmgen pos.
- TICK_DIV, 50000, clk cycles per ramp tick (1 ms at 50 MHz); must be >= 2.
- ARM_TICKS, 2000, ticks neutral is held in ARMING before RUN; must be >= 1.
- NEUTRAL, 128, neutral/stop position, POS_W bits.
- STEP, 1, maximum change of pwm_pos per tick; must be >= 1.

Ports:
- clk, in, 1: system clock (clk1_50 domain).
- rst, in, 1: reset, asynchronous, active-high.
- arm, in, 1: level; 1 requests armed operation, 0 returns to IDLE.
- kill, in, 1: level; emergency stop.
- cmd_valid, in, 1: command valid.
- cmd_ready, out, 1: command accepted when cmd_valid && cmd_ready.
- cmd_pos, in, POS_W: target position.
- pwm_ena, out, 1: to pwmgen ena.
- pwm_pos, out, POS_W: to pwmgen pos.
- state, out, 2: IDLE=0, ARMING=1, RUN=2, FAULT=3.
- at_target, out, 1: 1 when state==RUN and pwm_pos==target.

Behaviour:
- Reset: all outputs registered. On rst:
  - state=IDLE, pwm_ena=0, pwm_pos=NEUTRAL, cmd_ready=0, at_target=0.
  - Internal target=NEUTRAL, tick counter=0, arm counter=0.
- Reset mid-operation takes effect immediately, regardless of state.
- Tick generator:
  - Counter runs 0..TICK_DIV-1 and wraps.
  - tick=1 for one cycle when counter==TICK_DIV-1.
  - Free-running in all states; never reset except by rst.
- FSM (transitions on clk edge; priority top-down):
  1. kill=1 in any state -> FAULT next cycle.
     - FAULT: pwm_ena=0, pwm_pos=NEUTRAL, cmd_ready=0.
     - Exits to IDLE only when kill=0 and arm=0 in the same cycle.
  2. arm=0 in ARMING or RUN -> IDLE.
     - pwm_ena=0, pwm_pos=NEUTRAL, target=NEUTRAL.
  3. IDLE, arm=1 -> ARMING.
     - pwm_ena=1, pwm_pos=NEUTRAL, arm counter=0.
  4. ARMING: arm counter increments on each tick.
     - On the tick that brings it to ARM_TICKS -> RUN, with target=NEUTRAL.
     - pwm_ena stays 1.
  5. RUN: pwm_ena=1, cmd_ready=1.
- Outputs follow state with one-cycle latency: registered together with the state transition.
- Command handshake:
  - cmd_ready is 1 only while state==RUN and no kill/arm-drop transition is being taken that cycle.
  - On cmd_valid && cmd_ready, target <= cmd_pos.
  - Commands presented in other states are not accepted and do not stall anything.
  - Multiple accepted commands between ticks: the last one wins.
- Ramp (RUN only, on tick):
  - If pwm_pos < target: pwm_pos += min(STEP, target - pwm_pos).
  - If pwm_pos > target: pwm_pos -= min(STEP, pwm_pos - target).
  - No overshoot, no wrap at 0 or 2^POS_W-1; arithmetic is done in POS_W+1 bits.
  - Command accepted in the same cycle as a tick: that tick uses the old target; the new target applies from the next tick.
- at_target is registered and reflects the post-update pwm_pos/target values; it is 0 outside RUN.
- Simultaneous events:
  - kill and arm-drop together -> FAULT.
  - kill with rst -> reset wins.

Test Plan (TICK_DIV=4, ARM_TICKS=3, STEP=2, NEUTRAL=128 unless noted):
1. Reset then arm=1 -> next cycle state=1, pwm_ena=1, pwm_pos=128; state=2 and cmd_ready=1 on the cycle after the 3rd tick; pwm_pos stays 128 throughout.
2. In RUN, accept cmd_pos=135 -> pwm_pos 130,132,134,135 on successive ticks (no overshoot); at_target=1 after 135.
3. In RUN at 135, accept cmd_pos=0 then cmd_pos=131 before the next tick -> pwm_pos 133 then 131; at_target=1. With STEP=255, POS_W=8: cmd 255 from 0 -> 255 in one tick, no wrap.
4. Assert kill for 1 cycle mid-ramp -> next cycle state=3, pwm_ena=0, pwm_pos=128, cmd_ready=0. Stays in FAULT while arm=1 after kill drops; arm=0 -> IDLE.
5. Drop arm during ARMING after 2 ticks -> IDLE, pwm_ena=0. Re-arm -> full 3-tick arming count restarts.
6. Assert rst asynchronously mid-RUN between clock edges -> outputs return to reset values immediately, without waiting for a clock edge; cmd_valid held high in IDLE is never accepted.

Source files
------------

// File: rtl/uuv_throttle_ctrl_if.sv
// Position-command channel into the throttle controller.
// Ports: cmd_valid/cmd_pos from the command source, cmd_ready back to it.
// Handshake: a command transfers on a cycle where cmd_valid && cmd_ready.
interface uuv_throttle_ctrl_if #(
   parameter int POS_W = 8
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [POS_W-1:0] cmd_pos;

   modport master (output cmd_valid, output cmd_pos, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_pos, output cmd_ready);
endinterface

// File: rtl/uuv_throttle_ctrl.sv
// Throttle sequencer for the thruster PWM generator: ESC arming, rate-limited
// slewing toward commanded position, and an immediate kill to a safe output.
// Ports: clk/rst; arm_i/kill_i levels; cmd (slave) position commands;
//        pwm_ena_o/pwm_pos_o to pwmgen; state_o and at_target_o status.
// Latency: outputs registered, one cycle after the deciding edge. Commands are
// accepted only in RUN; they are never stalled elsewhere, just not taken.
module uuv_throttle_ctrl #(
   parameter int POS_W     = 8,
   parameter int TICK_DIV  = 50000,
   parameter int ARM_TICKS = 2000,
   parameter int NEUTRAL   = 128,
   parameter int STEP      = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                arm_i,
   input  logic                kill_i,
   uuv_throttle_ctrl_if.slave  cmd,
   output logic                pwm_ena_o,
   output logic [POS_W-1:0]    pwm_pos_o,
   output logic [1:0]          state_o,
   output logic                at_target_o
);

   localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int ARM_W  = $clog2(ARM_TICKS + 1);

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [ARM_W-1:0]  ARM_DONE  = ARM_W'(ARM_TICKS);
   localparam logic [POS_W-1:0]  NEUTRAL_P = POS_W'(NEUTRAL);
   localparam logic [POS_W:0]    STEP_P    = (POS_W + 1)'(STEP);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ARMING = 2'd1,
      S_RUN    = 2'd2,
      S_FAULT  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic               pwm_ena_q, pwm_ena_d;
   logic [POS_W-1:0]   pwm_pos_q, pwm_pos_d;
   logic [POS_W-1:0]   target_q, target_d;
   logic [ARM_W-1:0]   arm_cnt_q, arm_cnt_d;
   logic               cmd_ready_q, cmd_ready_d;
   logic               at_target_q, at_target_d;
   logic [TICK_W-1:0]  tick_cnt_q;
   logic               tick;
   logic               cmd_ready;
   logic               cmd_acc;

   // Ramp arithmetic is one bit wider so the differences can never wrap.
   logic [POS_W:0]     pos_x, tgt_x, diff_up, diff_dn, step_up, step_dn;
   logic [POS_W:0]     ramp_x;
   logic [POS_W-1:0]   ramp_pos;

   // ------------------------------------------------------------------
   // Free-running ramp tick; only rst restarts it.
   // ------------------------------------------------------------------
   assign tick = (tick_cnt_q == TICK_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt_q <= '0;
      end else if (tick) begin
         tick_cnt_q <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_q + 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Handshake. The registered ready is masked by the same-cycle kill and
   // arm-drop so that a command is never acknowledged on the cycle the
   // controller is leaving RUN.
   // ------------------------------------------------------------------
   assign cmd_ready     = cmd_ready_q && arm_i && !kill_i;
   assign cmd.cmd_ready = cmd_ready;
   assign cmd_acc       = cmd.cmd_valid && cmd_ready;

   // ------------------------------------------------------------------
   // One ramp step toward the current (pre-accept) target, clamped so it
   // lands exactly on the target instead of overshooting.
   // ------------------------------------------------------------------
   always_comb begin
      pos_x   = {1'b0, pwm_pos_q};
      tgt_x   = {1'b0, target_q};
      diff_up = tgt_x - pos_x;
      diff_dn = pos_x - tgt_x;
      step_up = (diff_up < STEP_P) ? diff_up : STEP_P;
      step_dn = (diff_dn < STEP_P) ? diff_dn : STEP_P;
      ramp_x  = pos_x;
      if (pos_x < tgt_x) begin
         ramp_x = pos_x + step_up;
      end else if (pos_x > tgt_x) begin
         ramp_x = pos_x - step_dn;
      end
      // Clamped result lies between pos and target, so the top bit is 0.
      ramp_pos = POS_W'(ramp_x);
   end

   // ------------------------------------------------------------------
   // Next-state and registered-output logic.
   // ------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      pwm_ena_d   = pwm_ena_q;
      pwm_pos_d   = pwm_pos_q;
      target_d    = target_q;
      arm_cnt_d   = arm_cnt_q;
      cmd_ready_d = 1'b0;
      at_target_d = 1'b0;

      if (kill_i) begin
         state_d   = S_FAULT;
         pwm_ena_d = 1'b0;
         pwm_pos_d = NEUTRAL_P;
         target_d  = NEUTRAL_P;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (arm_i) begin
                  state_d   = S_ARMING;
                  pwm_ena_d = 1'b1;
                  pwm_pos_d = NEUTRAL_P;
                  arm_cnt_d = '0;
               end
            end
            S_ARMING: begin
               if (!arm_i) begin
                  state_d   = S_IDLE;
                  pwm_ena_d = 1'b0;
                  pwm_pos_d = NEUTRAL_P;
                  target_d  = NEUTRAL_P;
               end else if (tick) begin
                  arm_cnt_d = arm_cnt_q + 1'b1;
                  if (arm_cnt_d == ARM_DONE) begin
                     state_d  = S_RUN;
                     target_d = NEUTRAL_P;
                  end
               end
            end
            S_RUN: begin
               if (!arm_i) begin
                  state_d   = S_IDLE;
                  pwm_ena_d = 1'b0;
                  pwm_pos_d = NEUTRAL_P;
                  target_d  = NEUTRAL_P;
               end else begin
                  // A command accepted on a tick cycle only steers later ticks.
                  if (tick) begin
                     pwm_pos_d = ramp_pos;
                  end
                  if (cmd_acc) begin
                     target_d = cmd.cmd_pos;
                  end
               end
            end
            S_FAULT: begin
               if (!arm_i) begin
                  state_d = S_IDLE;
               end
            end
            default: begin
               state_d   = S_FAULT;
               pwm_ena_d = 1'b0;
               pwm_pos_d = NEUTRAL_P;
            end
         endcase
      end

      cmd_ready_d = (state_d == S_RUN);
      at_target_d = (state_d == S_RUN) && (pwm_pos_d == target_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         pwm_ena_q   <= 1'b0;
         pwm_pos_q   <= NEUTRAL_P;
         target_q    <= NEUTRAL_P;
         arm_cnt_q   <= '0;
         cmd_ready_q <= 1'b0;
         at_target_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pwm_ena_q   <= pwm_ena_d;
         pwm_pos_q   <= pwm_pos_d;
         target_q    <= target_d;
         arm_cnt_q   <= arm_cnt_d;
         cmd_ready_q <= cmd_ready_d;
         at_target_q <= at_target_d;
      end
   end

   assign pwm_ena_o   = pwm_ena_q;
   assign pwm_pos_o   = pwm_pos_q;
   assign state_o     = state_q;
   assign at_target_o = at_target_q;

endmodule
